// File: rtl/regfile_param_1w_nr.sv
// regfile_param_1w_nr
//   Parametrised register file with one byte-masked write port and NREAD
//   independent read ports. Each read port is a 3-stage pipeline:
//     S1 flops address/valid, S2 flops a one-hot entry select,
//     S3 produces data as an AND-OR reduction over all entries (no address mux).
//   Each byte carries a valid bit so reset acts as a clear without touching the
//   data array: bytes never written since reset read back as 0x00.
//   A write presented in the same cycle as S3 to the same entry is bypassed
//   into the read data so the read sees it.
//
// Ports
//   clock        in  single clock, posedge
//   reset_n      in  synchronous active-low reset
//   rvalid       in  [NREAD]         read request per port
//   raddr        in  [NREAD*AW]      read address, port p at [p*AW +: AW]
//   wena         in  write enable
//   waddr        in  [AW]            write address (>= DEPTH ignored)
//   wdata        in  [WIDTH]         write data
//   wbe          in  [NB]            byte enables
//   rdata_valid  out [NREAD]         read data valid, 3 cycles after request
//   rdata        out [NREAD*WIDTH]   read data, port p at [p*WIDTH +: WIDTH]
module regfile_param_1w_nr #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 128,
  parameter int NREAD = 2,
  parameter int AW    = $clog2(DEPTH),
  parameter int NB    = WIDTH / 8
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic [NREAD-1:0]       rvalid,
  input  logic [NREAD*AW-1:0]    raddr,
  input  logic                   wena,
  input  logic [AW-1:0]          waddr,
  input  logic [WIDTH-1:0]       wdata,
  input  logic [NB-1:0]          wbe,
  output logic [NREAD-1:0]       rdata_valid,
  output logic [NREAD*WIDTH-1:0] rdata
);

  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  // Storage (data not reset) and per-byte valid bits (reset)
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [NB-1:0]    bv_q  [DEPTH];

  // Read pipeline state
  logic [NREAD-1:0] v1_q, v2_q, v3_q;
  logic [AW-1:0]    a1_q [NREAD];
  logic [AW-1:0]    a2_q [NREAD];
  logic [DEPTH-1:0] oh_d [NREAD];
  logic [DEPTH-1:0] oh_q [NREAD];
  logic [WIDTH-1:0] rd_d [NREAD];
  logic [WIDTH-1:0] rd_q [NREAD];

  logic wr_ok;

  function automatic logic [WIDTH-1:0] byte_mask(input logic [NB-1:0] m);
    logic [WIDTH-1:0] r;
    r = '0;
    for (int unsigned b = 0; b < NB; b++) begin
      r[b*8 +: 8] = {8{m[b]}};
    end
    return r;
  endfunction

  always_comb begin
    wr_ok = wena & ({1'b0, waddr} < DEPTH_C);
  end

  // Data array: only enabled bytes of an in-range write outside reset
  always_ff @(posedge clock) begin
    if (reset_n && wr_ok) begin
      for (int unsigned b = 0; b < NB; b++) begin
        if (wbe[b]) begin
          mem_q[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      for (int unsigned e = 0; e < DEPTH; e++) begin
        bv_q[e] <= '0;
      end
    end else if (wr_ok) begin
      bv_q[waddr] <= bv_q[waddr] | wbe;
    end
  end

  // S2 select: one-hot of the S1 address; naturally all-zero when the request
  // is invalid or the address is beyond DEPTH.
  always_comb begin
    for (int unsigned p = 0; p < NREAD; p++) begin
      oh_d[p] = '0;
      for (int unsigned e = 0; e < DEPTH; e++) begin
        oh_d[p][e] = v1_q[p] && (a1_q[p] == AW'(e));
      end
    end
  end

  // S3 data: AND-OR over entries, then the same-cycle write overrides its
  // enabled bytes. waddr must be in range for a bypass, so an out-of-range
  // S2 address can never pick up write data.
  always_comb begin
    for (int unsigned p = 0; p < NREAD; p++) begin
      rd_d[p] = '0;
      for (int unsigned e = 0; e < DEPTH; e++) begin
        rd_d[p] = rd_d[p] | (mem_q[e] & byte_mask(bv_q[e]) & {WIDTH{oh_q[p][e]}});
      end
      if (wr_ok && (waddr == a2_q[p])) begin
        for (int unsigned b = 0; b < NB; b++) begin
          if (wbe[b]) begin
            rd_d[p][b*8 +: 8] = wdata[b*8 +: 8];
          end
        end
      end
    end
  end

  // Address / select flops carry no reset; their valids gate everything.
  always_ff @(posedge clock) begin
    for (int unsigned p = 0; p < NREAD; p++) begin
      a1_q[p] <= raddr[p*AW +: AW];
      a2_q[p] <= a1_q[p];
      oh_q[p] <= oh_d[p];
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      v1_q <= '0;
      v2_q <= '0;
      v3_q <= '0;
      for (int unsigned p = 0; p < NREAD; p++) begin
        rd_q[p] <= '0;
      end
    end else begin
      v1_q <= rvalid;
      v2_q <= v1_q;
      v3_q <= v2_q;
      for (int unsigned p = 0; p < NREAD; p++) begin
        if (v2_q[p]) begin
          rd_q[p] <= rd_d[p];
        end
      end
    end
  end

  always_comb begin
    rdata_valid = v3_q;
    rdata       = '0;
    for (int unsigned p = 0; p < NREAD; p++) begin
      rdata[p*WIDTH +: WIDTH] = rd_q[p];
    end
  end

endmodule

// File: tb/tb_regfile_param_1w_nr.sv
module tb_regfile_param_1w_nr;

  localparam int WIDTH = 32;
  localparam int DEPTH = 100;
  localparam int NREAD = 2;
  localparam int AW    = $clog2(DEPTH);
  localparam int NB    = WIDTH / 8;

  logic                   clock = 1'b0;
  logic                   reset_n;
  logic [NREAD-1:0]       rvalid;
  logic [NREAD*AW-1:0]    raddr;
  logic                   wena;
  logic [AW-1:0]          waddr;
  logic [WIDTH-1:0]       wdata;
  logic [NB-1:0]          wbe;
  logic [NREAD-1:0]       rdata_valid;
  logic [NREAD*WIDTH-1:0] rdata;

  regfile_param_1w_nr #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .NREAD (NREAD)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .rvalid      (rvalid),
    .raddr       (raddr),
    .wena        (wena),
    .waddr       (waddr),
    .wdata       (wdata),
    .wbe         (wbe),
    .rdata_valid (rdata_valid),
    .rdata       (rdata)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [WIDTH-1:0] port_data(input int p);
    return rdata[p*WIDTH +: WIDTH];
  endfunction

  // ---------------- behavioural model ----------------
  // A read issued in cycle T returns the memory as it stands after every
  // write up to and including cycle T+2; reset wipes contents and drops
  // every outstanding request.
  typedef struct {
    int port;
    int addr;
    int cyc;
  } req_t;

  logic [7:0]       mb [DEPTH][NB];
  bit               mv [DEPTH][NB];
  req_t             rq [$];
  int               cyc = 0;
  bit               armed = 0;
  logic             exp_v [NREAD];
  logic [WIDTH-1:0] exp_d [NREAD];

  function automatic logic [WIDTH-1:0] model_read(input int a);
    logic [WIDTH-1:0] r;
    r = '0;
    if (a < DEPTH) begin
      for (int b = 0; b < NB; b++) begin
        if (mv[a][b]) r[b*8 +: 8] = mb[a][b];
      end
    end
    return r;
  endfunction

  always @(posedge clock) begin
    if (!reset_n) begin
      for (int a = 0; a < DEPTH; a++)
        for (int b = 0; b < NB; b++) mv[a][b] = 0;
      rq.delete();
      for (int p = 0; p < NREAD; p++) begin
        exp_v[p] = 1'b0;
        exp_d[p] = '0;
      end
      armed = 1;
    end else begin
      if (wena && int'(waddr) < DEPTH) begin
        for (int b = 0; b < NB; b++) begin
          if (wbe[b]) begin
            mb[waddr][b] = wdata[b*8 +: 8];
            mv[waddr][b] = 1;
          end
        end
      end
      for (int p = 0; p < NREAD; p++) exp_v[p] = 1'b0;
      while (rq.size() > 0 && rq[0].cyc == cyc - 2) begin
        req_t r;
        r = rq.pop_front();
        exp_v[r.port] = 1'b1;
        exp_d[r.port] = model_read(r.addr);
      end
      for (int p = 0; p < NREAD; p++) begin
        if (rvalid[p]) rq.push_back('{p, int'(raddr[p*AW +: AW]), cyc});
      end
    end
    cyc++;
  end

  // Single compare process: every cycle after the first reset edge
  always @(negedge clock) begin
    if (armed) begin
      for (int p = 0; p < NREAD; p++) begin
        check($sformatf("p%0d_valid", p), WIDTH'(rdata_valid[p]), WIDTH'(exp_v[p]));
        check($sformatf("p%0d_data", p), port_data(p), exp_d[p]);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(negedge clock);
  endtask

  task automatic idle();
    rvalid = '0;
    wena   = 1'b0;
    wbe    = '0;
  endtask

  task automatic set_write(input int a, input logic [WIDTH-1:0] d, input logic [NB-1:0] be);
    wena  = 1'b1;
    waddr = AW'(a);
    wdata = d;
    wbe   = be;
  endtask

  task automatic issue_read(input logic [NREAD-1:0] v, input int a0, input int a1);
    rvalid          = v;
    raddr[0 +: AW]  = AW'(a0);
    raddr[AW +: AW] = AW'(a1);
  endtask

  // Request issued now (cycle T); returns at the sample point of cycle T+3
  task automatic read_wait(input logic [NREAD-1:0] v, input int a0, input int a1);
    issue_read(v, a0, a1);
    tick();
    idle();
    tick();
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    rvalid  = '0;
    raddr   = '0;
    wena    = 1'b0;
    waddr   = '0;
    wdata   = '0;
    wbe     = '0;
    tick();
    tick();
    check("reset_valid", WIDTH'(rdata_valid), '0);
    check("reset_rdata0", port_data(0), 32'h0);
    check("reset_rdata1", port_data(1), 32'h0);
    reset_n = 1'b1;

    // unwritten entry reads zero
    read_wait(2'b01, 5, 0);
    check("rd_unwritten_v", WIDTH'(rdata_valid), 32'h1);
    check("rd_unwritten_d", port_data(0), 32'h0);

    // full write then dual-port read two cycles later
    set_write(10, 32'hDEADBEEF, 4'hF);
    tick();
    idle();
    tick();
    read_wait(2'b11, 10, 10);
    check("wr10_p0", port_data(0), 32'hDEADBEEF);
    check("wr10_p1", port_data(1), 32'hDEADBEEF);

    // byte masks
    set_write(3, 32'h11223344, 4'hF);
    tick();
    set_write(3, 32'hAABBCCDD, 4'b0101);
    tick();
    set_write(20, 32'hAABBCCDD, 4'b0010);
    tick();
    idle();
    read_wait(2'b11, 3, 20);
    check("mask_merge", port_data(0), 32'h11BB33DD);
    check("mask_fresh", port_data(1), 32'h0000CC00);

    // bypass window: write at T+2 seen
    set_write(7, 32'h1, 4'hF);
    tick();
    idle();
    tick();
    issue_read(2'b11, 7, 7);
    tick();
    idle();
    tick();
    set_write(7, 32'h2, 4'hF);
    tick();
    idle();
    check("byp_t2_p0", port_data(0), 32'h2);
    check("byp_t2_p1", port_data(1), 32'h2);

    // write at T+3 not seen
    set_write(7, 32'h1, 4'hF);
    tick();
    idle();
    tick();
    issue_read(2'b01, 7, 0);
    tick();
    idle();
    tick();
    tick();
    set_write(7, 32'h2, 4'hF);
    check("byp_t3", port_data(0), 32'h1);
    tick();
    idle();

    // write at T+1 seen through the array
    set_write(7, 32'h1, 4'hF);
    tick();
    idle();
    tick();
    issue_read(2'b01, 7, 0);
    tick();
    idle();
    set_write(7, 32'h2, 4'hF);
    tick();
    idle();
    tick();
    check("byp_t1", port_data(0), 32'h2);

    // streaming: fill then back-to-back reads, model checks every cycle
    for (int a = 0; a < DEPTH; a++) begin
      set_write(a, a * 32'h01010101, 4'hF);
      tick();
    end
    idle();
    for (int i = 0; i < 128; i++) begin
      issue_read(2'b11, i, 127 - i);
      tick();
    end
    idle();
    tick();
    tick();
    read_wait(2'b11, 120, 50);
    check("oor_data", port_data(0), 32'h0);
    check("oor_valid", WIDTH'(rdata_valid), 32'h3);
    check("stream_50", port_data(1), 32'h32323232);

    // randomized traffic with occasional reset pulses
    for (int i = 0; i < 3000; i++) begin
      wena  = 1'($urandom_range(0, 1));
      waddr = ($urandom_range(0, 1) != 0) ? AW'($urandom_range(0, 7)) : AW'($urandom_range(0, 127));
      wdata = $urandom;
      wbe   = NB'($urandom);
      rvalid = NREAD'($urandom);
      for (int p = 0; p < NREAD; p++) begin
        raddr[p*AW +: AW] = ($urandom_range(0, 1) != 0) ? AW'($urandom_range(0, 7))
                                                        : AW'($urandom_range(0, 127));
      end
      reset_n = ($urandom_range(0, 299) != 0);
      tick();
    end
    reset_n = 1'b1;
    idle();
    tick();
    tick();
    tick();

    // explicit reset mid-stream, then previously written data reads zero
    set_write(10, 32'hCAFEF00D, 4'hF);
    tick();
    for (int i = 0; i < 10; i++) begin
      issue_read(2'b11, 10, i);
      wena = 1'b0;
      reset_n = (i != 4);
      tick();
    end
    reset_n = 1'b1;
    idle();
    read_wait(2'b11, 10, 3);
    check("post_rst_10", port_data(0), 32'h0);
    check("post_rst_3", port_data(1), 32'h0);
    tick();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regfile_param_1w_nr.md
# regfile_param_1w_nr

Parametrised register file: one byte-masked write port, NREAD independent pipelined read ports. Reads use the team's flopped-address, flopped one-hot, AND-OR (no mux) structure with a fixed 3-cycle latency. Adds over the single-read-port 32x128 file: per-port read-valid tracking, write-to-read bypass for the late write, byte enables, and synchronous clear semantics via per-byte valid bits. Used as the architectural/scratch register array in datapaths needing more than one operand per cycle.

## Interface
- WIDTH, 32, data width in bits; must be a multiple of 8.
- DEPTH, 128, number of entries; need not be a power of two.
- NREAD, 2, number of read ports (1..8).
- AW, $clog2(DEPTH), address width (derived; do not override).
- NB, WIDTH/8, bytes per entry (derived).

- clock  in  1  single clock, all logic on posedge.
- reset_n  in  1  synchronous, active-low reset.
- rvalid  in  NREAD  read request per port.
- raddr  in  NREAD*AW  read address, port p at [p*AW +: AW].
- wena  in  1  write enable.
- waddr  in  AW  write address.
- wdata  in  WIDTH  write data.
- wbe  in  NB  byte enables; bit b covers wdata[8b+7:8b].
- rdata_valid  out  NREAD  per-port read data valid.
- rdata  out  NREAD*WIDTH  read data, port p at [p*WIDTH +: WIDTH].

## Operation
- Storage: DEPTH x WIDTH array, not reset. Per-byte valid bits (DEPTH x NB), cleared by reset.
- Write: cycle with reset_n=1, wena=1, waddr<DEPTH: for each b with wbe[b]=1, store byte b and set its valid bit at the edge. wbe=0 is a no-op. waddr>=DEPTH ignored.
- Read pipeline per port p, request in cycle T:
  - S1 (edge end of T): flop raddr, rvalid.
  - S2 (edge end of T+1): flop one-hot of address (all-zero if address>=DEPTH or request invalid), flop valid.
  - S3 (edge end of T+2): rdata = OR over entries of (entry & byte-valid mask & one-hot), i.e. no address mux; flop valid into rdata_valid.
- Unwritten bytes (valid bit 0) read as 0x00. Out-of-range reads return 0 with rdata_valid=1.
- Bypass: if a write is presented in cycle T+2 with waddr equal to the flopped S2 address, enabled bytes take wdata bytes instead of array bytes. Writes in cycles <=T+1 are visible through the array. Writes in cycles >=T+3 not visible.
- All ports independent; any ports may read same address in the same cycle; all bypass identically.
- rdata holds its last value when rdata_valid=0 (not forced to zero), except after reset.

## Timing
- Read latency exactly 3 cycles: request in cycle T -> rdata/rdata_valid in cycle T+3. Full throughput, one read per port per cycle, no stalls, no backpressure.
- Write latency 1: data readable by a request issued in cycle T >= Tw-2 (via bypass at Tw=T+2, array otherwise).
- Reset (reset_n=0 sampled at edge): all byte-valid bits, pipeline valids and rdata_valid cleared; rdata cleared to 0. Writes in a reset cycle are ignored. In-flight reads are dropped: no rdata_valid pulse for requests issued in the 3 cycles before/while reset was low. First post-reset request (cycle after reset_n returns 1) returns 0s for all addresses.
- All outputs are registered; no combinational input->output path.

## Test plan
- Reset then read port0 addr 5 in cycle 0 -> cycle 3 rdata_valid[0]=1, rdata0=0x00000000.
- Write 0xDEADBEEF wbe=0xF to addr 10, then read addr 10 on both ports 2 cycles later -> both ports return 0xDEADBEEF 3 cycles after request.
- Byte mask: write 0x11223344 wbe=0xF to addr 3, then 0xAABBCCDD wbe=0b0101 -> read returns 0x11BB33DD; on fresh entry, wbe=0b0010 with 0xAABBCCDD -> read returns 0x0000CC00.
- Bypass boundary: read addr 7 (holding 0x1) in cycle T; write 0x2 to addr 7 in cycle T+2 -> rdata 0x2; write in T+3 instead -> rdata 0x1; write in T+1 -> 0x2.
- Streaming: back-to-back reads of addrs 0..127 on port0 and 127..0 on port1 with pre-filled data=addr*0x01010101 -> every cycle valid, correct data, 3-cycle latency; out-of-range (DEPTH=100, addr 120) -> 0.
- Reset mid-stream: reads issued every cycle, reset_n low one cycle -> rdata_valid deasserts, no valid pulse for dropped requests, all previously written data reads 0 afterwards.
